// File: rtl/core_pkg.sv
// core_pkg: shared core-wide types for the pipeline stage bundles.
//   XLEN         datapath width (only 32 is supported)
//   exmem_reg_t  execute -> memory bundle
//   memwb_reg_t  memory -> writeback bundle
package core_pkg;

    parameter int unsigned XLEN = 32;

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

    typedef struct packed {
        logic            expt_valid;
        logic [3:0]      expt_cause;
        logic [XLEN-1:0] expt_value;
        logic [1:0]      mem_type;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] rs2_data;
        logic [1:0]      reg_wb_src;
        logic [XLEN-1:0] inst_imm;
        logic [XLEN-1:0] inst_pc;
        logic [4:0]      rd_addr;
        logic [11:0]     csr_addr;
    } exmem_reg_t;

    typedef struct packed {
        logic [1:0]      reg_wb_src;
        logic [XLEN-1:0] inst_imm;
        logic [XLEN-1:0] inst_pc;
        logic [XLEN-1:0] alu_res;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] csr_rd_data;
        logic [XLEN-1:0] load_data;
        logic            expt_valid;
        logic [3:0]      expt_cause;
        logic [XLEN-1:0] expt_value;
    } memwb_reg_t;

endpackage

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Accepts one exmem bundle, performs its load/store over a valid/ready data
// memory port, formats load data, flags misaligned accesses and presents a
// registered memwb bundle to writeback.
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   flush_i                             kill the held/in-flight instruction
//   in_valid_i/in_ready_o/in_i          execute-side handshake and bundle
//   csr_rdata_i                         CSR read data, sampled at acceptance
//   dmem_req_valid_o/dmem_req_ready_i   memory request handshake
//   dmem_addr_o/we_o/wmask_o/wdata_o    word address, write enable, lanes, data
//   dmem_rsp_valid_i/dmem_rdata_i       load response
//   out_valid_o/out_ready_i/out_o       writeback-side handshake and bundle
module mem_stage
    import core_pkg::*;
#(
    parameter int unsigned Xlen = core_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  exmem_reg_t      in_i,
    input  logic [Xlen-1:0] csr_rdata_i,
    output logic            dmem_req_valid_o,
    input  logic            dmem_req_ready_i,
    output logic [Xlen-1:0] dmem_addr_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_wmask_o,
    output logic [Xlen-1:0] dmem_wdata_o,
    input  logic            dmem_rsp_valid_i,
    input  logic [Xlen-1:0] dmem_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output memwb_reg_t      out_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] KILL = 2'd3;

    logic [1:0]      state_q;
    exmem_reg_t      hold_q;
    logic [Xlen-1:0] csr_q;
    memwb_reg_t      out_q;
    logic            out_valid_q;

    logic            accept;
    logic            in_is_mem;
    logic            in_is_store;
    logic            in_misaligned;
    memwb_reg_t      accept_out;
    logic [Xlen-1:0] rdata_shifted;
    logic [Xlen-1:0] load_fmt;
    logic            hold_is_store;

    // csr_addr is consumed upstream by the CSR file; it only rides along here.
    logic unused_bits;
    assign unused_bits = ^{in_i.csr_addr, hold_q.csr_addr};

    function automatic memwb_reg_t make_out(input exmem_reg_t b,
                                            input logic [Xlen-1:0] csr,
                                            input logic [Xlen-1:0] ld);
        memwb_reg_t o;
        o.reg_wb_src  = b.reg_wb_src;
        o.inst_imm    = b.inst_imm;
        o.inst_pc     = b.inst_pc;
        o.alu_res     = b.alu_res;
        o.rd_addr     = b.rd_addr;
        o.csr_rd_data = csr;
        o.load_data   = ld;
        o.expt_valid  = b.expt_valid;
        o.expt_cause  = b.expt_cause;
        o.expt_value  = b.expt_value;
        return o;
    endfunction

    assign in_ready_o  = (state_q == IDLE) && (!out_valid_q || out_ready_i) && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign in_is_store = (in_i.mem_type == MEM_STORE);
    assign in_is_mem   = (in_i.mem_type == MEM_LOAD) || in_is_store;

    always_comb begin
        in_misaligned = 1'b0;
        case (in_i.funct3[1:0])
            2'b00:   in_misaligned = 1'b0;
            2'b01:   in_misaligned = in_i.alu_res[0];
            2'b10:   in_misaligned = |in_i.alu_res[1:0];
            default: in_misaligned = 1'b1;
        endcase
    end

    // Bundle written directly at acceptance (non-memory or exception path).
    // An incoming exception wins over a locally detected misalignment.
    always_comb begin
        accept_out = make_out(in_i, csr_rdata_i, '0);
        if (!in_i.expt_valid && in_is_mem && in_misaligned) begin
            accept_out.expt_valid = 1'b1;
            accept_out.expt_cause = in_is_store ? CAUSE_STORE_MISALIGNED
                                                : CAUSE_LOAD_MISALIGNED;
            accept_out.expt_value = in_i.alu_res;
        end
    end

    // Request fields come straight from the held bundle, so they stay
    // stable for as long as the request waits for ready.
    assign hold_is_store    = (hold_q.mem_type == MEM_STORE);
    assign dmem_req_valid_o = (state_q == REQ);
    assign dmem_addr_o      = {hold_q.alu_res[Xlen-1:2], 2'b00};
    assign dmem_we_o        = hold_is_store;

    always_comb begin
        dmem_wmask_o = 4'hF;
        dmem_wdata_o = hold_q.rs2_data;
        case (hold_q.funct3[1:0])
            2'b00: begin
                dmem_wmask_o = 4'b0001 << hold_q.alu_res[1:0];
                dmem_wdata_o = {4{hold_q.rs2_data[7:0]}};
            end
            2'b01: begin
                dmem_wmask_o = 4'b0011 << {hold_q.alu_res[1], 1'b0};
                dmem_wdata_o = {2{hold_q.rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign rdata_shifted = dmem_rdata_i >> {hold_q.alu_res[1:0], 3'b000};

    always_comb begin
        load_fmt = rdata_shifted;
        case (hold_q.funct3[1:0])
            2'b00: load_fmt = hold_q.funct3[2] ? {24'b0, rdata_shifted[7:0]}
                                               : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01: load_fmt = hold_q.funct3[2] ? {16'b0, rdata_shifted[15:0]}
                                               : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: ;
        endcase
    end

    // The output slot is always free by the time a memory op completes:
    // acceptance requires it to be empty or draining that same cycle, and
    // nothing else writes it while the op is outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            csr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        hold_q <= in_i;
                        csr_q  <= csr_rdata_i;
                        if (in_i.expt_valid || !in_is_mem || in_misaligned) begin
                            out_q       <= accept_out;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready_i) begin
                        if (hold_is_store) begin
                            state_q <= IDLE;
                            if (!flush_i) begin
                                out_q       <= make_out(hold_q, csr_q, '0);
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= flush_i ? KILL : WAIT;
                        end
                    end else if (flush_i) begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    // A flush coinciding with the response consumes that
                    // response here; waiting in KILL would never end.
                    if (dmem_rsp_valid_i) begin
                        state_q <= IDLE;
                        if (!flush_i) begin
                            out_q       <= make_out(hold_q, csr_q, load_fmt);
                            out_valid_q <= 1'b1;
                        end
                    end else if (flush_i) begin
                        state_q <= KILL;
                    end
                end
                KILL: begin
                    if (dmem_rsp_valid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;

endmodule
